// File: rtl/pipeline_fetch_pkg.sv
// Shared constants for the instruction fetch unit: redirect-select encoding
// and default reset/interrupt/exception vectors.
package pipeline_fetch_pkg;

    localparam logic [2:0] PC_SEQ    = 3'd0;
    localparam logic [2:0] PC_BRANCH = 3'd1;
    localparam logic [2:0] PC_JUMP   = 3'd2;
    localparam logic [2:0] PC_REG    = 3'd3;
    localparam logic [2:0] PC_IRQ    = 3'd4;
    localparam logic [2:0] PC_EXC    = 3'd5;

    localparam logic [31:0] DEF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

endpackage

// File: rtl/pipeline_fetch_if.sv
// Fetch unit bus bundle: redirect inputs, instruction-memory handshake and
// the decode-side queue head. master = fetch unit, slave = its environment.
interface pipeline_fetch_if #(
    parameter int AW = 32
);
    logic [2:0]    pc_src;
    logic          br_take;
    logic [AW-1:0] con_ba;
    logic [25:0]   jt;
    logic [AW-1:0] bus_a;
    logic          redir_valid;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;

    logic          if_valid;
    logic [31:0]   if_instr;
    logic [AW-1:0] if_pc;
    logic [AW-1:0] if_pc4;
    logic          id_ready;

    modport master (
        input  pc_src, br_take, con_ba, jt, bus_a, redir_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4
    );

    modport slave (
        output pc_src, br_take, con_ba, jt, bus_a, redir_valid,
        output imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc4
    );

endinterface

// File: rtl/pipeline_fetch_fifo.sv
// Fetch queue: power-of-two circular buffer with synchronous flush and a
// combinational head (o_data valid whenever o_empty is low).
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_data
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      r_wr;
    logic [PW:0]      r_rd;
    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_count = r_wr - r_rd;
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (o_count == (PW+1)'(DEPTH));
    assign o_data  = r_mem[r_rd[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push && !o_full) r_wr <= r_wr + (PW+1)'(1);
            if (i_pop && !o_empty) r_rd <= r_rd + (PW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full && !i_flush) r_mem[r_wr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction fetch unit: PC generation, redirect/flush with stale-response
// dropping, and a fetch queue. Define FETCH_IRQ_EN to enable the IRQ redirect.
module pipeline_fetch
    import pipeline_fetch_pkg::*;
#(
    parameter int            AW        = 32,
    parameter int            QDEPTH    = 4,
    parameter logic [AW-1:0] RESET_VEC = AW'(DEF_RESET_VEC),
    parameter logic [AW-1:0] IRQ_VEC   = AW'(DEF_IRQ_VEC),
    parameter logic [AW-1:0] EXC_VEC   = AW'(DEF_EXC_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    pipeline_fetch_if.master  bus
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int EW = AW + 32;

`ifdef FETCH_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic [AW-1:0] r_fpc;
    logic [AW-1:0] r_rsp_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;

    logic          w_redirect;
    logic [AW-1:0] w_target;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_outst_nxt;
    logic [EW-1:0] w_head;

    always_comb begin
        w_redirect = 1'b0;
        w_target   = r_fpc;
        case (bus.pc_src)
            PC_BRANCH: begin
                w_redirect = bus.br_take;
                w_target   = bus.con_ba;
            end
            PC_JUMP: begin
                w_redirect = 1'b1;
                w_target   = {r_fpc[AW-1:28], bus.jt, 2'b00};
            end
            PC_REG: begin
                w_redirect = 1'b1;
                w_target   = bus.bus_a;
            end
            PC_IRQ: begin
                w_redirect = IRQ_EN;
                w_target   = IRQ_VEC;
            end
            PC_EXC: begin
                w_redirect = 1'b1;
                w_target   = EXC_VEC;
            end
            PC_SEQ: ;
            default: ;
        endcase
        w_redirect = w_redirect & bus.redir_valid;
    end

    // In-flight requests plus queued entries never exceed QDEPTH, so every
    // response always has a free slot.
    assign bus.imem_req  = reset && !w_redirect && !w_full &&
                           (({1'b0, r_outst} + {1'b0, w_count}) < (CW+1)'(QDEPTH));
    assign bus.imem_addr = r_fpc;

    assign w_fire      = bus.imem_req && bus.imem_gnt;
    assign w_push      = bus.imem_rvalid && (r_drop == '0) && !w_redirect;
    assign w_pop       = bus.if_valid && bus.id_ready && !w_redirect;
    assign w_outst_nxt = r_outst + CW'(w_fire) - CW'(bus.imem_rvalid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fpc    <= RESET_VEC;
            r_rsp_pc <= RESET_VEC;
            r_outst  <= '0;
            r_drop   <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            if (w_redirect) begin
                r_fpc    <= w_target;
                r_rsp_pc <= w_target;
                // everything still in flight after this cycle belongs to the old path
                r_drop   <= w_outst_nxt;
            end else begin
                if (w_fire) r_fpc <= r_fpc + AW'(4);
                if (w_push) r_rsp_pc <= r_rsp_pc + AW'(4);
                if (bus.imem_rvalid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_data  ({r_rsp_pc, bus.imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_data  (w_head)
    );

    assign bus.if_valid = !w_empty;
    assign bus.if_instr = w_empty ? 32'd0 : w_head[31:0];
    assign bus.if_pc    = w_empty ? '0 : w_head[EW-1:32];
    assign bus.if_pc4   = w_empty ? '0 : w_head[EW-1:32] + AW'(4);

endmodule

// File: tb/tb_pipeline_fetch.sv
// Directed bench for pipeline_fetch: vector table plus hand sequences for
// reset, stale-response dropping, queue stall and the IRQ option.
module tb_pipeline_fetch;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipeline_fetch_if #(.AW(32)) fif ();

    pipeline_fetch #(.AW(32), .QDEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fif)
    );

`ifdef FETCH_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct {
        logic        rv;
        logic [2:0]  src;
        logic        br;
        logic [31:0] tgt;
        logic [25:0] jt;
        logic        rdy;
        logic        gnt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] mq[$];
    logic        hold = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_fire = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rv, input logic [2:0] src, input logic br,
                          input logic [31:0] tgt, input logic [25:0] jt,
                          input logic rdy, input logic gnt);
        fif.redir_valid = rv;
        fif.pc_src      = src;
        fif.br_take     = br;
        fif.con_ba      = tgt;
        fif.bus_a       = tgt;
        fif.jt          = jt;
        fif.id_ready    = rdy;
        fif.imem_gnt    = gnt;
    endtask

    task automatic add(input logic rv, input logic [2:0] src, input logic br,
                       input logic [31:0] tgt, input logic [25:0] jt, input logic rdy,
                       input logic gnt, input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] epc);
        vec_t v;
        v.rv = rv; v.src = src; v.br = br; v.tgt = tgt; v.jt = jt; v.rdy = rdy;
        v.gnt = gnt; v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
        tbl.push_back(v);
    endtask

    task automatic seq(input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] epc);
        add(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 1'b1, 1'b1, ereq, eaddr, evalid, epc);
    endtask

    // memory model: responds in order, one cycle after grant unless held
    task automatic drive_cycle();
        logic [31:0] a;
        if (!hold && mq.size() > 0) begin
            a = mq.pop_front();
            fif.imem_rvalid = 1'b1;
            fif.imem_rdata  = ~a;
        end else begin
            fif.imem_rvalid = 1'b0;
            fif.imem_rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic end_cycle();
        if (fif.imem_req && fif.imem_gnt) begin
            mq.push_back(fif.imem_addr);
            n_fire++;
        end
        @(negedge clk);
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        mq.delete();
        fif.imem_rvalid = 1'b0;
        fif.imem_rdata  = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(fif.imem_req), 32'd0);
        chk("rst_valid", 32'(fif.if_valid), 32'd0);
        chk("rst_instr", fif.if_instr, 32'd0);
        chk("rst_pc",    fif.if_pc, 32'd0);
        chk("rst_pc4",   fif.if_pc4, 32'd0);
        reset = 1'b1;
    endtask

    task automatic chk_head(input string name, input logic [31:0] epc);
        chk({name, "_valid"}, 32'(fif.if_valid), 32'd1);
        chk({name, "_pc"},    fif.if_pc, epc);
        chk({name, "_pc4"},   fif.if_pc4, epc + 32'd4);
        chk({name, "_instr"}, fif.if_instr, ~epc);
    endtask

    initial begin
        int k;
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 1'b1, 1'b1);

        seq(1, 32'h8000_0000, 0, 32'h0);
        seq(1, 32'h8000_0004, 0, 32'h0);
        seq(1, 32'h8000_0008, 1, 32'h8000_0000);
        seq(1, 32'h8000_000C, 1, 32'h8000_0004);
        add(1, 3'd1, 0, 32'h8000_0100, 26'h0, 1, 1, 1, 32'h8000_0010, 1, 32'h8000_0008);
        seq(1, 32'h8000_0014, 1, 32'h8000_000C);
        add(0, 3'd0, 0, 32'h0, 26'h0, 0, 1, 1, 32'h8000_0018, 1, 32'h8000_0010);
        add(0, 3'd0, 0, 32'h0, 26'h0, 0, 1, 1, 32'h8000_001C, 1, 32'h8000_0010);
        add(0, 3'd0, 0, 32'h0, 26'h0, 0, 1, 0, 32'h0, 1, 32'h8000_0010);
        add(0, 3'd0, 0, 32'h0, 26'h0, 0, 1, 0, 32'h0, 1, 32'h8000_0010);
        seq(0, 32'h0, 1, 32'h8000_0010);
        seq(1, 32'h8000_0020, 1, 32'h8000_0014);
        seq(1, 32'h8000_0024, 1, 32'h8000_0018);
        seq(1, 32'h8000_0028, 1, 32'h8000_001C);
        seq(1, 32'h8000_002C, 1, 32'h8000_0020);
        add(1, 3'd1, 1, 32'h8000_0100, 26'h0, 1, 1, 0, 32'h0, 1, 32'h8000_0024);
        seq(1, 32'h8000_0100, 0, 32'h0);
        seq(1, 32'h8000_0104, 0, 32'h0);
        seq(1, 32'h8000_0108, 1, 32'h8000_0100);
        add(1, 3'd6, 0, 32'h0000_0040, 26'h0, 1, 1, 1, 32'h8000_010C, 1, 32'h8000_0104);
        seq(1, 32'h8000_0110, 1, 32'h8000_0108);
        add(1, 3'd5, 0, 32'h0, 26'h0, 1, 1, 0, 32'h0, 1, 32'h8000_010C);
        seq(1, 32'h8000_0008, 0, 32'h0);
        seq(1, 32'h8000_000C, 0, 32'h0);
        seq(1, 32'h8000_0010, 1, 32'h8000_0008);
        add(1, 3'd2, 0, 32'h0, 26'h123, 1, 1, 0, 32'h0, 1, 32'h8000_000C);
        seq(1, 32'h8000_048C, 0, 32'h0);
        seq(1, 32'h8000_0490, 0, 32'h0);
        seq(1, 32'h8000_0494, 1, 32'h8000_048C);
        add(1, 3'd3, 0, 32'hFFFF_FFFC, 26'h0, 1, 1, 0, 32'h0, 1, 32'h8000_0490);
        seq(1, 32'hFFFF_FFFC, 0, 32'h0);
        seq(1, 32'h0000_0000, 0, 32'h0);
        seq(1, 32'h0000_0004, 1, 32'hFFFF_FFFC);
        seq(1, 32'h0000_0008, 1, 32'h0000_0000);
        add(0, 3'd3, 0, 32'h1234_5678, 26'h0, 1, 1, 1, 32'h0000_000C, 1, 32'h0000_0004);
        add(0, 3'd0, 0, 32'h0, 26'h0, 1, 0, 1, 32'h0000_0010, 1, 32'h0000_0008);
        seq(1, 32'h0000_0010, 1, 32'h0000_000C);
        seq(1, 32'h0000_0014, 0, 32'h0);
        seq(1, 32'h0000_0018, 1, 32'h0000_0010);

        reset_dut();
        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].rv, tbl[i].src, tbl[i].br, tbl[i].tgt, tbl[i].jt, tbl[i].rdy, tbl[i].gnt);
            drive_cycle();
            chk($sformatf("row%0d_req", i), 32'(fif.imem_req), 32'(tbl[i].ereq));
            if (tbl[i].ereq)
                chk($sformatf("row%0d_addr", i), fif.imem_addr, tbl[i].eaddr);
            chk($sformatf("row%0d_valid", i), 32'(fif.if_valid), 32'(tbl[i].evalid));
            if (tbl[i].evalid)
                chk_head($sformatf("row%0d", i), tbl[i].epc);
            end_cycle();
        end

        // reset in the middle of outstanding traffic, then drop 3 stale responses
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 1'b1, 1'b1);
        hold = 1'b1;
        repeat (2) begin drive_cycle(); end_cycle(); end
        #3 reset = 1'b0;
        #1;
        chk("midrst_req",   32'(fif.imem_req), 32'd0);
        chk("midrst_valid", 32'(fif.if_valid), 32'd0);
        @(negedge clk);
        reset_dut();
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            chk($sformatf("stale_c%0d_req", c), 32'(fif.imem_req), 32'd1);
            chk($sformatf("stale_c%0d_addr", c), fif.imem_addr, 32'h8000_0000 + 32'(4 * c));
            end_cycle();
        end
        hold = 1'b0;
        set_in(1'b1, 3'd1, 1'b1, 32'h8000_0100, 26'h0, 1'b1, 1'b1);
        drive_cycle();
        chk("stale_redir_req",   32'(fif.imem_req), 32'd0);
        chk("stale_redir_valid", 32'(fif.if_valid), 32'd0);
        end_cycle();
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            chk($sformatf("stale_d%0d_addr", c), fif.imem_addr, 32'h8000_0100 + 32'(4 * c));
            chk($sformatf("stale_d%0d_valid", c), 32'(fif.if_valid), 32'd0);
            end_cycle();
        end
        drive_cycle();
        chk_head("stale_head", 32'h8000_0100);
        end_cycle();

        // decode stalled from reset: only QDEPTH requests, nothing lost afterwards
        reset_dut();
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 1'b0, 1'b1);
        n_fire = 0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle();
            if (c == 9) chk("stall_req_low", 32'(fif.imem_req), 32'd0);
            end_cycle();
        end
        chk("stall_fires", 32'(n_fire), 32'd4);
        fif.id_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            drive_cycle();
            if (fif.if_valid) begin
                chk($sformatf("drain%0d_pc", k), fif.if_pc, 32'h8000_0000 + 32'(4 * k));
                chk($sformatf("drain%0d_instr", k), fif.if_instr, ~(32'h8000_0000 + 32'(4 * k)));
                k++;
            end
            end_cycle();
        end
        chk("drain_count", 32'(k), 32'd8);

        // interrupt select: redirect only when the option is built in
        reset_dut();
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 1'b1, 1'b1);
        repeat (4) begin drive_cycle(); end_cycle(); end
        set_in(1'b1, 3'd4, 1'b0, 32'h0, 26'h0, 1'b1, 1'b1);
        drive_cycle();
        chk("irq_req", 32'(fif.imem_req), IRQ_EN ? 32'd0 : 32'd1);
        if (!IRQ_EN) chk("irq_addr", fif.imem_addr, 32'h8000_0010);
        end_cycle();
        set_in(1'b0, 3'd0, 1'b0, 32'h0, 26'h0, 1'b1, 1'b1);
        drive_cycle();
        chk("irq_next_addr", fif.imem_addr, IRQ_EN ? 32'h8000_0004 : 32'h8000_0014);
        end_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_fetch.md
PIPELINE_FETCH -- requirements
Module: pipeline_fetch

Interface
REQ-001 SHALL have parameter AW, default 32: PC/address width.
REQ-002 SHALL have parameter QDEPTH, default 4: fetch-queue entries; power of two, 2..16.
REQ-003 SHALL have parameter RESET_VEC, default 32'h80000000: PC after reset.
REQ-004 SHALL have parameter IRQ_VEC, default 32'h80000004: interrupt target.
REQ-005 SHALL have parameter EXC_VEC, default 32'h80000008: exception target.
REQ-006 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc_src  in  3  redirect select: 0 sequential, 1 branch, 2 jump, 3 register, 4 IRQ, 5 exception, 6-7 sequential.
- br_take  in  1  branch condition; qualifies pc_src==1.
- con_ba  in  AW  branch target.
- jt  in  26  jump index.
- bus_a  in  AW  register-jump target.
- redir_valid  in  1  pc_src/targets valid this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  AW  fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  in-order response valid.
- imem_rdata  in  32  response word.
- if_valid  out  1  queue head valid.
- if_instr  out  32  head instruction.
- if_pc  out  AW  head PC.
- if_pc4  out  AW  head PC+4.
- id_ready  in  1  decode consumes head (low = stall).

Function
REQ-007 Redirect SHALL occur when redir_valid and (pc_src in {2,3,4,5} or (pc_src==1 and br_take)).
REQ-008 Redirect targets SHALL be: con_ba; {fpc[AW-1:28],jt,2'b00} using current fetch PC fpc; bus_a; IRQ_VEC; EXC_VEC.
REQ-009 imem_req SHALL be high when outstanding+occupancy < QDEPTH and no redirect is active this cycle; imem_addr = fpc.
REQ-010 On imem_req and imem_gnt, fpc SHALL advance by 4, modulo 2^AW.
REQ-011 On redirect, fpc SHALL load the target next cycle; queue SHALL flush; responses to earlier outstanding requests SHALL be dropped via a drop counter loaded with outstanding minus any response accepted that cycle.
REQ-012 Non-dropped responses SHALL be pushed with their PC, in order; head SHALL be visible with zero-cycle latency.
REQ-013 Pop SHALL occur when if_valid and id_ready; push and pop in the same cycle SHALL keep occupancy constant; with a full queue no request SHALL issue, so no overflow.
REQ-014 Redirect and grant in the same cycle SHALL count the granted request as stale.
REQ-015 Outstanding count SHALL be +1 on grant, -1 on response, unchanged when both occur.
REQ-016 if_pc4 SHALL equal if_pc+4 modulo 2^AW.

Reset
REQ-017 While reset is low: fpc=RESET_VEC, queue empty, outstanding=0, drop=0, imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pc4=0.
REQ-018 Reset assertion mid-transaction SHALL discard all outstanding responses; the first request SHALL issue in the first cycle after release.

Configuration
REQ-019 With FETCH_IRQ_EN defined, pc_src==4 SHALL redirect to IRQ_VEC; without it, pc_src==4 SHALL behave as sequential (no redirect, no flush).

Structure
REQ-020 A shared package SHALL hold the pc_src encoding constants and the default vector constants.
REQ-021 The queue SHALL be a sub-module fetch_fifo (parametrised depth/width, push/pop/full/empty/flush).

Verification
REQ-022 Reset release, gnt=1, rvalid one cycle after grant: imem_addr sequence 80000000, 80000004, 80000008...; if_pc matches.
REQ-023 id_ready=0 for 10 cycles: exactly QDEPTH requests issue, then imem_req=0; no entry lost when released.
REQ-024 pc_src=1, br_take=1, con_ba=80000100 with 3 outstanding: the 3 stale responses are dropped; next if_pc=80000100.
REQ-025 pc_src=1, br_take=0: no flush; sequence continues.
REQ-026 pc_src=4: with FETCH_IRQ_EN, next imem_addr=80000004; without it, sequence continues.
REQ-027 fpc=FFFFFFFC after jump via bus_a, grant: next imem_addr=00000000; if_pc4=00000000.
